// File: rtl/add_pkg.sv
// ============================================================================
// Module   : add_pkg
// Brief    : Shared constants, FSM state type and counter-width helper for the
//            batch accumulator.
// Revision : 1.0
// ============================================================================
`default_nettype none

package add_pkg;

    localparam int c_DATA_W = 8;
    localparam int c_ACC_W  = 16;
    localparam int c_BATCH  = 4;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

    // Wide enough to hold every count from 0 to batch inclusive.
    function automatic int cnt_width(input int batch);
        return $clog2(batch + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/add8_core.sv
// ============================================================================
// Module   : add8_core
// Brief    : Combinational DATA_W-bit ripple-carry adder (a + b + cin).
// Revision : 1.0
// ============================================================================
`default_nettype none

module add8_core
    import add_pkg::*;
#(
    parameter int DATA_W = c_DATA_W
) (
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic              i_cin,
    output logic [DATA_W-1:0] o_sum,
    output logic              o_cout
);

    logic [DATA_W:0] w_carry;

    assign w_carry[0] = i_cin;

    generate
        for (genvar i = 0; i < DATA_W; i++) begin : g_bit
            assign o_sum[i]       = i_a[i] ^ i_b[i] ^ w_carry[i];
            assign w_carry[i + 1] = (i_a[i] & i_b[i]) | (w_carry[i] & (i_a[i] ^ i_b[i]));
        end
    endgenerate

    assign o_cout = w_carry[DATA_W];

endmodule

`default_nettype wire

// File: rtl/add_batch_accum.sv
// ============================================================================
// Module   : add_batch_accum
// Brief    : Accepts BATCH operand pairs, sums each through add8_core and
//            presents the accumulated total on a valid/ready handshake.
//            Build option ADD_ACCUM_SATURATE_EN: clamp on overflow instead of wrap.
// Revision : 1.0
// ============================================================================
`default_nettype none

module add_batch_accum
    import add_pkg::*;
#(
    parameter  int DATA_W = c_DATA_W,
    parameter  int ACC_W  = c_ACC_W,
    parameter  int BATCH  = c_BATCH,
    localparam int CNT_W  = cnt_width(BATCH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              cin,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic              ovf,
    output logic [CNT_W-1:0]  cnt_out
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ACC_W-1:0]   r_acc;
    logic               r_ovf;
    logic [CNT_W-1:0]   r_cnt;

    logic [DATA_W-1:0]  w_sum;
    logic               w_cout;
    logic [ACC_W-1:0]   w_term;
    logic [ACC_W:0]     w_sum_wide;
    logic               w_acc_carry;
    logic [ACC_W-1:0]   w_acc_nxt;
    logic               w_accept;
    logic               w_last;
    logic               w_consume;

    add8_core #(
        .DATA_W (DATA_W)
    ) u_add (
        .i_a    (a),
        .i_b    (b),
        .i_cin  (cin),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    assign w_accept  = in_valid && (r_state == ACCUM);
    assign w_consume = out_ready && (r_state == DONE);
    assign w_last    = (r_cnt == CNT_W'(BATCH - 1));

    // One extra bit on the add exposes the true overflow of acc + term.
    assign w_term      = ACC_W'({w_cout, w_sum});
    assign w_sum_wide  = {1'b0, r_acc} + {1'b0, w_term};
    assign w_acc_carry = w_sum_wide[ACC_W];

`ifdef ADD_ACCUM_SATURATE_EN
    assign w_acc_nxt = w_acc_carry ? {ACC_W{1'b1}} : w_sum_wide[ACC_W-1:0];
`else
    assign w_acc_nxt = w_sum_wide[ACC_W-1:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = ACCUM;
        end else begin
            case (r_state)
                ACCUM:   if (w_accept && w_last) w_state_nxt = DONE;
                DONE:    if (out_ready)          w_state_nxt = ACCUM;
                default: w_state_nxt = ACCUM;
            endcase
        end
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            ACCUM:   in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: in_ready  = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (clear || w_consume) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            r_acc <= w_acc_nxt;
            r_cnt <= r_cnt + CNT_W'(1);
            r_ovf <= r_ovf | w_acc_carry;
        end
    end

    assign acc_out = r_acc;
    assign ovf     = r_ovf;
    assign cnt_out = r_cnt;

endmodule

`default_nettype wire
